// File: rtl/uart_cnt_tx.sv
// uart_cnt_tx: counts rising edges on a count button and, when the send
// button is pressed again, transmits the count over UART as fixed-width
// decimal ASCII (leading zeros included, most significant digit first).
// Optional build macro: UART_CNT_TX_CRLF_EN appends CR then LF to each send.
module uart_cnt_tx #(
    parameter int CLK_DIV   = 5,
    parameter int CNT_W     = 10,
    parameter int DIGITS    = 3,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sed,
    input  logic i_cnt,
    output logic o_txd,
    output logic o_led,
    output logic o_busy,
    output logic o_done
);

`ifdef UART_CNT_TX_CRLF_EN
    localparam int NCHARS = DIGITS + 2;
`else
    localparam int NCHARS = DIGITS;
`endif
    localparam int PAR_BITS   = (PARITY != 0) ? 1 : 0;
    localparam int FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int BAUD_W     = $clog2(CLK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int CHAR_W     = (NCHARS > 1) ? $clog2(NCHARS) : 1;
    localparam int STEP_W     = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam int BCD_W      = 4 * DIGITS;
    localparam int MAX_CNT    = (10 ** DIGITS) - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_CONV,
        ST_SEND
    } state_t;

    state_t              state_q, state_d;
    logic                sed_prev_q;
    logic                cnt_prev_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CHAR_W-1:0]   char_q, char_d;
    logic                done_q, done_d;

    logic                sed_edge;
    logic                cnt_edge;
    logic [BCD_W-1:0]    bcd_adj;
    logic [7:0]          chars [NCHARS];
    logic [7:0]          cur_char;
    logic [DATA_BITS-1:0] cur_data;
    logic                parity_bit;
    logic [FRAME_BITS-1:0] frame;

    assign sed_edge = i_sed & ~sed_prev_q;
    assign cnt_edge = i_cnt & ~cnt_prev_q;

    // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dabble
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
    end

    // Character table: digits most significant first, then the optional line ending.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chars
        assign chars[gi] = 8'h30 + {4'h0, bcd_q[4*(DIGITS-1-gi) +: 4]};
    end
`ifdef UART_CNT_TX_CRLF_EN
    assign chars[DIGITS]   = 8'h0D;
    assign chars[DIGITS+1] = 8'h0A;
`endif

    assign cur_char   = chars[char_q];
    assign cur_data   = cur_char[DATA_BITS-1:0];
    assign parity_bit = (PARITY == 1) ? ~(^cur_data) : (^cur_data);

    // Assemble the current frame, bit 0 first on the wire: start, data, parity, stops.
    always_comb begin
        frame = '1;
        frame[0] = 1'b0;
        frame[DATA_BITS:1] = cur_data;
        if (PARITY != 0) begin
            frame[DATA_BITS+1] = parity_bit;
        end
    end

    // Next-state logic for the IDLE/COUNT/CONV/SEND controller and its counters.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        char_d  = char_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sed_edge) begin
                    state_d = ST_COUNT;
                    count_d = '0;
                end
            end
            ST_COUNT: begin
                if (cnt_edge && (count_q != CNT_W'(MAX_CNT))) begin
                    count_d = count_q + CNT_W'(1);
                end
                // A press on the same cycle as send is already folded into count_d.
                if (sed_edge) begin
                    state_d = ST_CONV;
                    bin_d   = count_d;
                    bcd_d   = '0;
                    step_d  = '0;
                end
            end
            ST_CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                if (step_q == STEP_W'(CNT_W - 1)) begin
                    state_d = ST_SEND;
                    baud_d  = '0;
                    bit_d   = '0;
                    char_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_SEND: begin
                if (baud_q == BAUD_W'(CLK_DIV - 1)) begin
                    baud_d = '0;
                    if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        bit_d = '0;
                        if (char_q == CHAR_W'(NCHARS - 1)) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            char_d = char_q + CHAR_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and button history; reset abandons any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            sed_prev_q <= 1'b0;
            cnt_prev_q <= 1'b0;
            count_q    <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            char_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sed_prev_q <= i_sed;
            cnt_prev_q <= i_cnt;
            count_q    <= count_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            step_q     <= step_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            char_q     <= char_d;
            done_q     <= done_d;
        end
    end

    assign o_txd  = (state_q == ST_SEND) ? frame[bit_q] : 1'b1;
    assign o_led  = (state_q == ST_COUNT);
    assign o_busy = (state_q == ST_CONV) || (state_q == ST_SEND);
    assign o_done = done_q;

endmodule

// File: tb/tb_uart_cnt_tx.sv
// tb_uart_cnt_tx: three uart_cnt_tx instances with different frame formats,
// driven by a table of press-count rounds plus hand-written reset sequences.
// Expected characters are adjusted when UART_CNT_TX_CRLF_EN is defined.
module tb_uart_cnt_tx;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] sed;
    logic [2:0] cnt;
    wire  [2:0] txd;
    wire  [2:0] led;
    wire  [2:0] busy;
    wire  [2:0] done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instance 0: defaults, 8N1, 3 digits.
    uart_cnt_tx u_dut0 (
        .i_clk(clk), .i_rst(rst[0]), .i_sed(sed[0]), .i_cnt(cnt[0]),
        .o_txd(txd[0]), .o_led(led[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    // Instance 1: single digit, odd parity, 4 clocks per bit.
    uart_cnt_tx #(.CLK_DIV(4), .CNT_W(4), .DIGITS(1), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst[1]), .i_sed(sed[1]), .i_cnt(cnt[1]),
        .o_txd(txd[1]), .o_led(led[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    // Instance 2: 7 data bits, even parity, 2 stop bits.
    uart_cnt_tx #(.CLK_DIV(5), .CNT_W(10), .DIGITS(3), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .i_clk(clk), .i_rst(rst[2]), .i_sed(sed[2]), .i_cnt(cnt[2]),
        .o_txd(txd[2]), .o_led(led[2]), .o_busy(busy[2]), .o_done(done[2])
    );

    typedef struct {
        int          inst;
        int          presses;
        bit          simul;
        bit          noise;
        int          nchars;
        logic [39:0] chs;
    } vec_t;

    function automatic int p_div(int k);
        return (k == 1) ? 4 : 5;
    endfunction
    function automatic int p_cntw(int k);
        return (k == 1) ? 4 : 10;
    endfunction
    function automatic int p_db(int k);
        return (k == 2) ? 7 : 8;
    endfunction
    function automatic int p_par(int k);
        return (k == 1) ? 1 : ((k == 2) ? 2 : 0);
    endfunction
    function automatic int p_stop(int k);
        return (k == 2) ? 2 : 1;
    endfunction
    function automatic int p_fb(int k);
        return 1 + p_db(k) + ((p_par(k) != 0) ? 1 : 0) + p_stop(k);
    endfunction

    // Expected line level for bit b of a frame carrying character ch.
    function automatic logic exp_bit(int k, logic [7:0] ch, int b);
        int   db;
        logic p;
        db = p_db(k);
        p  = 1'b0;
        for (int i = 0; i < db; i++) p = p ^ ch[i];
        if (b == 0) return 1'b0;
        if (b <= db) return ch[b-1];
        if (p_par(k) != 0 && b == db + 1) return (p_par(k) == 1) ? ~p : p;
        return 1'b1;
    endfunction

    function automatic vec_t mk(int k, int pr, bit si, bit no, int nc, logic [39:0] c);
        vec_t v;
        v.inst = k; v.presses = pr; v.simul = si; v.noise = no;
        v.nchars = nc; v.chs = c;
`ifdef UART_CNT_TX_CRLF_EN
        v.chs    = v.chs | (40'h0A0D << (8 * nc));
        v.nchars = nc + 2;
`endif
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One complete IDLE->COUNT->CONV->SEND round on instance k, checked cycle by cycle.
    task automatic run_round(int id, int k, int presses, bit simul, bit noise,
                             int nchars, logic [39:0] chs);
        int          n;
        int          errs;
        int          fb;
        int          div;
        int          db;
        int          tick;
        logic [15:0] fr;
        logic [7:0]  ch;
        logic [7:0]  got;
        logic [7:0]  want;
        div = p_div(k);
        fb  = p_fb(k);
        db  = p_db(k);
        sed[k] = 1'b1;
        @(negedge clk);
        chk($sformatf("r%0d led_count", id), int'(led[k]), 1);
        sed[k] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < presses; i++) begin
            cnt[k] = 1'b1;
            @(negedge clk);
            cnt[k] = 1'b0;
            @(negedge clk);
        end
        if (simul) cnt[k] = 1'b1;
        sed[k] = 1'b1;
        @(negedge clk);
        sed[k] = 1'b0;
        cnt[k] = 1'b0;
        chk($sformatf("r%0d busy_rise", id), int'(busy[k]), 1);
        chk($sformatf("r%0d led_off", id), int'(led[k]), 0);
        n = 0;
        while (txd[k] === 1'b1 && n < 64) begin
            n++;
            if (noise) begin
                cnt[k] = n[0];
                sed[k] = (n % 3 == 0);
            end
            @(negedge clk);
        end
        chk($sformatf("r%0d conv_len", id), n, p_cntw(k));
        errs = 0;
        tick = 0;
        for (int c = 0; c < nchars; c++) begin
            ch = chs[8*c +: 8];
            fr = '0;
            for (int b = 0; b < fb; b++) begin
                for (int d = 0; d < div; d++) begin
                    if (txd[k] !== exp_bit(k, ch, b)) errs++;
                    if (done[k] !== 1'b0) errs++;
                    if (busy[k] !== 1'b1) errs++;
                    if (d == div / 2) fr[b] = txd[k];
                    tick++;
                    if (noise) begin
                        cnt[k] = tick[0];
                        sed[k] = (tick % 5 == 0);
                    end
                    @(negedge clk);
                end
            end
            got  = '0;
            for (int i = 0; i < db; i++) got[i] = fr[i+1];
            want = (db == 7) ? (ch & 8'h7F) : ch;
            chk($sformatf("r%0d char%0d", id, c), int'(got), int'(want));
            if (k == 2 && c == 2) begin
                chk($sformatf("r%0d frame_7e2", id), int'(fr[10:0]), int'(11'b11001101010));
            end
        end
        cnt[k] = 1'b0;
        sed[k] = 1'b0;
        chk($sformatf("r%0d stream_errs", id), errs, 0);
        chk($sformatf("r%0d done_pulse", id), int'(done[k]), 1);
        chk($sformatf("r%0d busy_end", id), int'(busy[k]), 0);
        chk($sformatf("r%0d txd_idle", id), int'(txd[k]), 1);
        @(negedge clk);
        chk($sformatf("r%0d done_clear", id), int'(done[k]), 0);
        $display("[TB] round %0d inst %0d presses %0d simul %0d noise %0d chars %0d errs %0d",
                 id, k, presses, simul, noise, nchars, errs);
    endtask

    vec_t tbl [7];

    initial begin
        int n;
        int bad;
        tbl[0] = mk(0, 10, 1'b0, 1'b0, 3, 40'h0000303130);  // "010"
        tbl[1] = mk(0,  8, 1'b0, 1'b0, 3, 40'h0000383030);  // "008", count cleared
        tbl[2] = mk(1, 12, 1'b0, 1'b0, 1, 40'h0000000039);  // saturates at 9
        tbl[3] = mk(2,  5, 1'b0, 1'b0, 3, 40'h0000353030);  // "005" 7E2
        tbl[4] = mk(0,  9, 1'b1, 1'b0, 3, 40'h0000303130);  // 9 + simultaneous press
        tbl[5] = mk(0,  7, 1'b0, 1'b1, 3, 40'h0000373030);  // noise during CONV/SEND
        tbl[6] = mk(1,  3, 1'b0, 1'b1, 1, 40'h0000000033);  // "3", odd parity, noise

        rst = 3'b111;
        sed = 3'b000;
        cnt = 3'b000;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset txd%0d", k), int'(txd[k]), 1);
            chk($sformatf("reset led%0d", k), int'(led[k]), 0);
            chk($sformatf("reset busy%0d", k), int'(busy[k]), 0);
            chk($sformatf("reset done%0d", k), int'(done[k]), 0);
        end
        rst = 3'b000;
        @(negedge clk);

        // Count presses while IDLE must not leave IDLE.
        cnt[0] = 1'b1;
        @(negedge clk);
        cnt[0] = 1'b0;
        @(negedge clk);
        chk("idle cnt ignored led", int'(led[0]), 0);
        chk("idle cnt ignored busy", int'(busy[0]), 0);

        for (int i = 0; i < 7; i++) begin
            run_round(i, tbl[i].inst, tbl[i].presses, tbl[i].simul, tbl[i].noise,
                      tbl[i].nchars, tbl[i].chs);
        end

        // Reset in the middle of data bit 1 of the first character.
        sed[0] = 1'b1;
        @(negedge clk);
        sed[0] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cnt[0] = 1'b1;
            @(negedge clk);
            cnt[0] = 1'b0;
            @(negedge clk);
        end
        sed[0] = 1'b1;
        @(negedge clk);
        sed[0] = 1'b0;
        n = 0;
        while (txd[0] === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("rstmid conv_len", n, 10);
        repeat (11) @(negedge clk);
        chk("rstmid in_frame busy", int'(busy[0]), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("rstmid txd", int'(txd[0]), 1);
        chk("rstmid busy", int'(busy[0]), 0);
        chk("rstmid led", int'(led[0]), 0);
        chk("rstmid done", int'(done[0]), 0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || done[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
        end
        chk("rstmid quiet after", bad, 0);
        $display("[TB] reset mid-frame sequence done");

        run_round(7, 0, 0, 1'b0, 1'b0,
`ifdef UART_CNT_TX_CRLF_EN
                  5, 40'h0A0D303030
`else
                  3, 40'h0000303030
`endif
                  );

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_cnt_tx.md
Name: uart_cnt_tx

Overview:
- Button-driven UART transmitter: counts presses on a count button, then sends the count as fixed-width decimal ASCII.
- Parametrised successor of the single-character send/count wrapper, adding:
  - configurable baud divider, data bits, parity and stop bits;
  - multi-digit decimal output with counter saturation;
  - busy/done status.
- Sits between debounced board buttons and the board TX pin; o_led drives a status LED.

Parameters:
- CLK_DIV, 5: clock cycles per UART bit (≥2).
- CNT_W, 10: press counter width; must satisfy 2^CNT_W > 10^DIGITS−1.
- DIGITS, 3: decimal digits sent, leading zeros included (1..4).
- DATA_BITS, 8: data bits per frame (7 or 8); ASCII byte truncated to DATA_BITS LSBs.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits (1 or 2).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_sed  in  1  send/mode button (synchronous level); rising edge advances the mode.
- i_cnt  in  1  count button (synchronous level); rising edge increments the count; pulses must be ≥1 clock wide.
- o_txd  out 1  UART serial output, idle high.
- o_led  out 1  high while in COUNT.
- o_busy out 1  high in CONV and SEND.
- o_done out 1  one-cycle pulse on the cycle SEND exits.

Behaviour:
- Reset (i_rst high at a clock edge):
  - state = IDLE, count = 0; o_txd = 1, o_led = 0, o_busy = 0, o_done = 0 from the next edge.
  - Applies from any state; a frame in flight is abandoned with no trailing stop bit.
- Edge detect: one registered copy each of i_sed and i_cnt; edge = in & ~prev. Both registers clear to 0 on reset.
- IDLE:
  - i_sed edge -> COUNT; count cleared to 0 on this transition.
  - i_cnt edges ignored.
- COUNT:
  - Each i_cnt edge increments count; saturates at 10^DIGITS−1, no wrap.
  - i_sed edge -> CONV. If an i_cnt edge occurs on the same cycle, that press is counted first.
- CONV:
  - Binary-to-BCD by shift-add-3 (double dabble); takes exactly CNT_W cycles, then -> SEND.
  - i_sed and i_cnt ignored.
- SEND:
  - Characters, in order: DIGITS ASCII digits, most significant first, each 0x30 + BCD digit. Optional CR/LF follows (see Optional Feature).
  - Frame: start bit 0, data LSB first, parity bit if PARITY≠0, then STOP_BITS bits at 1. Every bit lasts exactly CLK_DIV clocks.
  - First start bit begins on the cycle after CONV ends. Consecutive frames are back-to-back with no idle gap.
  - Parity: odd makes the total count of 1s in data+parity odd; even makes it even.
  - After the last stop bit: o_done pulses for 1 cycle, state -> IDLE, count retained until the next IDLE->COUNT transition.
  - i_sed and i_cnt ignored for the whole of SEND.
- Outputs:
  - o_txd = 1 in every state except during frame bits.
  - o_busy = 1 exactly in CONV and SEND.
- Counters: baud counter runs 0..CLK_DIV−1; bit index and character index are sized to fit their maxima. No overflow permitted.

Optional Feature:
- Macro: UART_CNT_TX_CRLF_EN.
- Defined: after the digits, send CR (0x0D) then LF (0x0A); DIGITS+2 frames total.
- Undefined: digits only; DIGITS frames total.
- All other behaviour is identical in both builds.

Test Plan:
- Basic send: reset, i_sed, 10 i_cnt pulses, i_sed, defaults, macro off.
  - Response: o_led high during counting; o_busy rises.
  - After 10 CONV cycles, o_txd carries 0x30, 0x31, 0x30, each frame 10 bits × 5 clocks.
  - o_done pulses once, 150 clocks after SEND starts.
- Second round and saturation: a second round with 8 presses sends 0x30, 0x30, 0x38 (count cleared between rounds). DIGITS=1 with 12 presses sends 0x39 (saturated).
- Frame format: PARITY=2, STOP_BITS=2, DATA_BITS=7, count 5.
  - Each frame is 0, 7 data bits, parity, 1, 1.
  - Char 0x35 gives 7 bits 0110101 LSB-first and parity bit 0.
  - Frame length is 11 bits × CLK_DIV.
- CRLF build: with UART_CNT_TX_CRLF_EN defined, count 10 sends 0x30, 0x31, 0x30, 0x0D, 0x0A; o_done only after the LF stop bit.
- Reset mid-frame: assert i_rst during the 2nd data bit of the first character.
  - Next cycle: o_txd = 1, o_busy = 0, o_led = 0, no o_done.
  - A fresh IDLE->COUNT->send of 0 presses sends 0x30, 0x30, 0x30.
- Ignored and simultaneous inputs:
  - i_sed and i_cnt pulses during CONV/SEND do not change the bitstream or state.
  - i_cnt and i_sed edges on the same COUNT cycle: the press is counted (9 presses plus one simultaneous press sends "010").
